sipo_deframer: RTL and testbench

- Serial-to-parallel receive stage that sits directly downstream of PISO_Design.
- Consumes a serial bitstream with a bit-valid strobe and a start-of-word sync marker, and rebuilds WIDTH-bit words.
- Presents each word on a valid/ready output port through a one-entry holding register.
- Flags overruns and mid-word resynchronisation so the link between the two stages can be checked in system simulation.

---
 rtl/sipo_pkg.sv | 14 +
 rtl/word_hold_reg.sv | 32 +++
 rtl/sipo_deframer.sv | 132 +++++++++++++
 tb/tb_sipo_deframer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel deframer.
package sipo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width; a 2-bit word still needs one counter bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register for reassembled words.
module word_hold_reg
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             accept
);

    assign accept = out_valid & out_ready;

    // A load is taken only when the slot is empty or draining this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (load && (!out_valid || accept)) begin
            out_valid <= 1'b1;
            data_out  <= data;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// Serial-to-parallel receive stage: rebuilds WIDTH-bit words from a synced
// bitstream and presents them on a valid/ready port with overrun/framing flags.
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          CONTINUOUS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             sync_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             frame_err
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic               frame_err_nxt;
    logic               overrun_nxt;

    logic [WIDTH-1:0]   first_c;
    logic [WIDTH-1:0]   shifted_c;
    logic               word_done_c;
    logic               drop_c;
    logic               accept;

    // Register image of a word holding only bit 0, and of one more bit shifted in.
    always_comb begin
        if (MSB_FIRST) begin
            first_c   = WIDTH'(serial_in);
            shifted_c = {shreg[WIDTH-2:0], serial_in};
        end else begin
            first_c   = {serial_in, {(WIDTH-1){1'b0}}};
            shifted_c = {serial_in, shreg[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        shreg_nxt     = shreg;
        frame_err_nxt = 1'b0;
        word_done_c   = 1'b0;

        case (state)
            IDLE: begin
                if (bit_valid && sync_in) begin
                    shreg_nxt = first_c;
                    count_nxt = CNT_ONE;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    if (sync_in) begin
                        // Sync on a word boundary is legal; mid-word it drops the partial word.
                        frame_err_nxt = (count != '0);
                        shreg_nxt     = first_c;
                        count_nxt     = CNT_ONE;
                    end else begin
                        shreg_nxt = shifted_c;
                        if (count == CNT_LAST) begin
                            count_nxt   = '0;
                            word_done_c = 1'b1;
                            state_nxt   = CONTINUOUS ? SHIFT : IDLE;
                        end else begin
                            count_nxt = count + CNT_ONE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    assign drop_c = word_done_c & out_valid & ~accept;

    // A drop on the same edge as a clear keeps the flag set.
    always_comb begin
        overrun_nxt = overrun;
        if (drop_c) begin
            overrun_nxt = 1'b1;
        end else if (clr_overrun) begin
            overrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            shreg     <= shreg_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (word_done_c),
        .data      (shifted_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data_out  (parallel_out),
        .accept    (accept)
    );

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: an MSB-first continuous build and an LSB-first
// sync-per-word build share one stimulus stream and one reference model.
module tb_sipo_deframer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_in, bit_valid, sync_in, out_ready, clr_overrun;
    logic [W-1:0] pout_a, pout_b;
    logic         ov_a, ov_b, ovr_a, ovr_b, fe_a, fe_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1)) u_a (
        .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
        .sync_in(sync_in), .parallel_out(pout_a), .out_valid(ov_a),
        .out_ready(out_ready), .overrun(ovr_a), .clr_overrun(clr_overrun),
        .frame_err(fe_a)
    );

    sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) u_b (
        .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
        .sync_in(sync_in), .parallel_out(pout_b), .out_valid(ov_b),
        .out_ready(out_ready), .overrun(ovr_b), .clr_overrun(clr_overrun),
        .frame_err(fe_b)
    );

    // Reference model: index 0 mirrors u_a's parameters, index 1 mirrors u_b.
    bit         m_msb  [2] = '{1'b1, 1'b0};
    bit         m_cont [2] = '{1'b1, 1'b0};
    bit         m_in   [2];
    int         m_n    [2];
    bit [W-1:0] m_arr  [2];
    bit         m_hv   [2];
    bit [W-1:0] m_hd   [2];
    bit         m_ovr  [2];
    bit         m_fe   [2];

    logic [W-1:0] got_a[$];
    int           fe_cnt_a;

    typedef struct {
        bit         sv, bv, sy, rdy, clr;
        logic [W-1:0] pout;
        bit         vld, ovr, fe;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in[k]  = 1'b0;
            m_n[k]   = 0;
            m_arr[k] = '0;
            m_hv[k]  = 1'b0;
            m_hd[k]  = '0;
            m_ovr[k] = 1'b0;
            m_fe[k]  = 1'b0;
        end
    endtask

    // Bits are kept by arrival index; the word is assembled only on completion.
    task automatic model_edge(input bit sv, input bit bv, input bit sy, input bit rdy, input bit clr);
        for (int k = 0; k < 2; k++) begin
            bit         acc, blocked, done, fe_n;
            bit [W-1:0] w;
            acc     = m_hv[k] && rdy;
            blocked = m_hv[k] && !acc;
            done    = 1'b0;
            fe_n    = 1'b0;
            w       = '0;
            if (bv) begin
                if (sy) begin
                    fe_n        = m_in[k] && (m_n[k] != 0);
                    m_arr[k]    = '0;
                    m_arr[k][0] = sv;
                    m_n[k]      = 1;
                    m_in[k]     = 1'b1;
                end else if (m_in[k]) begin
                    m_arr[k][m_n[k]] = sv;
                    m_n[k]++;
                    if (m_n[k] == W) begin
                        for (int i = 0; i < W; i++) begin
                            if (m_msb[k]) w[W-1-i] = m_arr[k][i];
                            else          w[i]     = m_arr[k][i];
                        end
                        done    = 1'b1;
                        m_n[k]  = 0;
                        m_in[k] = m_cont[k];
                    end
                end
            end
            if (done && !blocked) begin
                m_hv[k] = 1'b1;
                m_hd[k] = w;
            end else if (acc) begin
                m_hv[k] = 1'b0;
            end
            if (done && blocked) m_ovr[k] = 1'b1;
            else if (clr)        m_ovr[k] = 1'b0;
            m_fe[k] = fe_n;
        end
    endtask

    task automatic check_model();
        chk("a_valid", 32'(ov_a), 32'(m_hv[0]));
        chk("a_data", 32'(pout_a), 32'(m_hd[0]));
        chk("a_overrun", 32'(ovr_a), 32'(m_ovr[0]));
        chk("a_frame_err", 32'(fe_a), 32'(m_fe[0]));
        chk("b_valid", 32'(ov_b), 32'(m_hv[1]));
        chk("b_data", 32'(pout_b), 32'(m_hd[1]));
        chk("b_overrun", 32'(ovr_b), 32'(m_ovr[1]));
        chk("b_frame_err", 32'(fe_b), 32'(m_fe[1]));
    endtask

    // One clock: drive inputs, log words u_a hands over, advance model, check.
    task automatic step(input bit sv, input bit bv, input bit sy, input bit rdy, input bit clr);
        serial_in   = sv;
        bit_valid   = bv;
        sync_in     = sy;
        out_ready   = rdy;
        clr_overrun = clr;
        #1;
        if (ov_a && rdy) got_a.push_back(pout_a);
        @(posedge clk);
        model_edge(sv, bv, sy, rdy, clr);
        #1;
        check_model();
        if (fe_a) fe_cnt_a++;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        serial_in = 0; bit_valid = 0; sync_in = 0; out_ready = 0; clr_overrun = 0;
        rst = 1'b0;
        #2;
        chk("rst_a_valid", 32'(ov_a), 32'd0);
        chk("rst_a_data", 32'(pout_a), 32'd0);
        chk("rst_a_overrun", 32'(ovr_a), 32'd0);
        chk("rst_a_frame_err", 32'(fe_a), 32'd0);
        chk("rst_b_valid", 32'(ov_b), 32'd0);
        chk("rst_b_data", 32'(pout_b), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        got_a.delete();
        fe_cnt_a = 0;
    endtask

    function automatic logic [W-1:0] got_at(input int idx);
        logic [W-1:0] v;
        v = 'x;
        if (idx < got_a.size()) v = got_a[idx];
        return v;
    endfunction

    initial begin
        bit [7:0] stream;
        stream = 8'b1101_0011;

        tbl[0] = '{1, 1, 1, 1, 0, 4'b0000, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 0, 4'b0000, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 1, 0, 4'b0000, 0, 0, 0};
        tbl[3] = '{0, 1, 0, 1, 0, 4'b1010, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 0, 4'b1010, 0, 0, 0};
        tbl[5] = '{1, 0, 0, 1, 0, 4'b1010, 0, 0, 0};

        do_reset();

        // Basic word 1010, out_valid for exactly one cycle.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].sv, tbl[i].bv, tbl[i].sy, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d_data", i), 32'(pout_a), 32'(tbl[i].pout));
            chk($sformatf("tbl%0d_valid", i), 32'(ov_a), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_overrun", i), 32'(ovr_a), 32'(tbl[i].ovr));
            chk($sformatf("tbl%0d_frame_err", i), 32'(fe_a), 32'(tbl[i].fe));
        end

        // Continuous stream, back to back and then with two-cycle gaps.
        for (int gap = 0; gap <= 2; gap += 2) begin
            do_reset();
            for (int i = 0; i < 8; i++) begin
                step(stream[7-i], 1'b1, (i == 0), 1'b1, 1'b0);
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 1, 0);
            chk($sformatf("cont_gap%0d_count", gap), 32'(got_a.size()), 32'd2);
            chk($sformatf("cont_gap%0d_word0", gap), 32'(got_at(0)), 32'(4'b1101));
            chk($sformatf("cont_gap%0d_word1", gap), 32'(got_at(1)), 32'(4'b0011));
        end

        // Overrun: second word dropped, flag cleared, held word accepted once.
        do_reset();
        step(1, 1, 1, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ovr_held_data", 32'(pout_a), 32'(4'b1111));
        chk("ovr_set", 32'(ovr_a), 32'd1);
        step(0, 0, 0, 0, 1);
        chk("ovr_cleared", 32'(ovr_a), 32'd0);
        step(0, 0, 0, 1, 0);
        chk("ovr_drained_valid", 32'(ov_a), 32'd0);
        chk("ovr_accept_count", 32'(got_a.size()), 32'd1);
        chk("ovr_accept_word", 32'(got_at(0)), 32'(4'b1111));

        // Load on the same edge the held word drains.
        do_reset();
        step(1, 1, 1, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(0, 1, 0, 1, 0);
        chk("same_edge_valid", 32'(ov_a), 32'd1);
        chk("same_edge_data", 32'(pout_a), 32'(4'b0110));
        chk("same_edge_overrun", 32'(ovr_a), 32'd0);
        step(0, 0, 0, 1, 0);

        // Mid-word resync.
        do_reset();
        step(1, 1, 1, 1, 0); step(1, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0); step(0, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
        chk("resync_fe_pulses", 32'(fe_cnt_a), 32'd1);
        chk("resync_count", 32'(got_a.size()), 32'd1);
        chk("resync_word", 32'(got_at(0)), 32'(4'b0010));

        // Reset with a pending word and a partial word, then unsynced bits.
        do_reset();
        step(1, 1, 1, 0, 0); step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0); step(0, 1, 0, 0, 0);
        chk("pre_rst_pending", 32'(ov_a), 32'd1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("unsynced_ignored", 32'(got_a.size()), 32'd0);
        step(1, 1, 1, 1, 0); step(1, 1, 0, 1, 0); step(0, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("post_rst_word", 32'(got_at(0)), 32'(4'b1100));

        // LSB-first build.
        do_reset();
        step(1, 1, 1, 1, 0); step(0, 1, 0, 1, 0); step(0, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
        chk("lsb_first_valid", 32'(ov_b), 32'd1);
        chk("lsb_first_data", 32'(pout_b), 32'(4'b0001));

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
